// File: rtl/i2c_sensor_target_if.sv
// Bus bundle for i2c_sensor_target: I2C pins plus the sensor-side
// read image / write data handshake.
`timescale 1ns/1ps
interface i2c_sensor_target_if #(
  parameter int unsigned RD_BYTES = 2
);
  logic                  scl_in;
  logic                  sda_in;
  logic                  sda_oe;
  logic [8*RD_BYTES-1:0] rd_image;
  logic [7:0]            wr_data;
  logic                  wr_valid;
  logic                  rd_start;
  logic                  busy;

  modport master (
    output scl_in, sda_in, rd_image,
    input  sda_oe, wr_data, wr_valid, rd_start, busy
  );

  modport slave (
    input  scl_in, sda_in, rd_image,
    output sda_oe, wr_data, wr_valid, rd_start, busy
  );
endinterface

// File: rtl/i2c_sensor_target.sv
// I2C target answering DEV_ADDR: byte writes to wr_data, wrapping reads of rd_image.
// Optional I2C_TGT_GLITCH_FILTER_EN adds a 3-sample majority filter on SCL/SDA.
`timescale 1ns/1ps
module i2c_sensor_target #(
  parameter logic [6:0]  DEV_ADDR = 7'h38,
  parameter int unsigned RD_BYTES = 2
) (
  input logic               clk,
  input logic               rst,
  i2c_sensor_target_if.slave io_bus
);
  localparam int unsigned IMG_W    = 8 * RD_BYTES;
  localparam logic [1:0]  IDX_LAST = 2'(RD_BYTES - 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_ADDR, ST_ADDR_ACK, ST_WR_BYTE,
    ST_WR_ACK, ST_RD_BYTE, ST_RD_ACK, ST_IGNORE
  } state_t;

  logic r_scl_s1, r_scl_s2, r_sda_s1, r_sda_s2;
  logic r_scl_d, r_sda_d;
  logic w_scl, w_sda;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_scl_s1 <= 1'b1; r_scl_s2 <= 1'b1;
      r_sda_s1 <= 1'b1; r_sda_s2 <= 1'b1;
    end else begin
      r_scl_s1 <= io_bus.scl_in; r_scl_s2 <= r_scl_s1;
      r_sda_s1 <= io_bus.sda_in; r_sda_s2 <= r_sda_s1;
    end
  end

`ifdef I2C_TGT_GLITCH_FILTER_EN
  logic [1:0] r_scl_h, r_sda_h;
  logic       r_scl_f, r_sda_f;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_scl_h <= '1; r_sda_h <= '1;
      r_scl_f <= 1'b1; r_sda_f <= 1'b1;
    end else begin
      r_scl_h <= {r_scl_h[0], r_scl_s2};
      r_sda_h <= {r_sda_h[0], r_sda_s2};
      r_scl_f <= (r_scl_s2 & r_scl_h[0]) | (r_scl_s2 & r_scl_h[1]) | (r_scl_h[0] & r_scl_h[1]);
      r_sda_f <= (r_sda_s2 & r_sda_h[0]) | (r_sda_s2 & r_sda_h[1]) | (r_sda_h[0] & r_sda_h[1]);
    end
  end
  assign w_scl = r_scl_f;
  assign w_sda = r_sda_f;
`else
  assign w_scl = r_scl_s2;
  assign w_sda = r_sda_s2;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_scl_d <= 1'b1;
      r_sda_d <= 1'b1;
    end else begin
      r_scl_d <= w_scl;
      r_sda_d <= w_sda;
    end
  end

  logic w_scl_rise, w_scl_fall, w_start, w_stop;
  assign w_scl_rise = w_scl & ~r_scl_d;
  assign w_scl_fall = ~w_scl & r_scl_d;
  assign w_start    = w_scl & r_scl_d & r_sda_d & ~w_sda;
  assign w_stop     = w_scl & r_scl_d & ~r_sda_d & w_sda;

  state_t           r_state, w_state_nx;
  logic [3:0]       r_bitcnt, w_cnt_nx;
  logic [6:0]       r_shift, w_shift_nx;
  logic             r_rw, w_rw_nx;
  logic [IMG_W-1:0] r_snap, w_snap_nx;
  logic [1:0]       r_idx, w_idx_nx, w_idx_inc;
  logic             r_sda_oe, w_oe_nx;
  logic             r_busy, w_busy_nx;
  logic [7:0]       r_wr_data, w_wr_data_nx;
  logic             r_wr_valid, w_wr_valid_nx;
  logic             r_rd_start, w_rd_start_nx;
  logic             w_cur_bit, w_nxt_msb;

  // The ACK phases use r_sda_oe as their half-marker: first fall drives, second releases.
  assign w_idx_inc = (r_idx == IDX_LAST) ? 2'd0 : r_idx + 2'd1;
  assign w_cur_bit = r_snap[IMG_W - 1 - 8 * int'(r_idx) - int'(r_bitcnt[2:0])];
  assign w_nxt_msb = r_snap[IMG_W - 1 - 8 * int'(w_idx_inc)];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_bitcnt   <= '0;
      r_shift    <= '0;
      r_rw       <= 1'b0;
      r_snap     <= '0;
      r_idx      <= '0;
      r_sda_oe   <= 1'b0;
      r_busy     <= 1'b0;
      r_wr_data  <= 8'h00;
      r_wr_valid <= 1'b0;
      r_rd_start <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_bitcnt   <= w_cnt_nx;
      r_shift    <= w_shift_nx;
      r_rw       <= w_rw_nx;
      r_snap     <= w_snap_nx;
      r_idx      <= w_idx_nx;
      r_sda_oe   <= w_oe_nx;
      r_busy     <= w_busy_nx;
      r_wr_data  <= w_wr_data_nx;
      r_wr_valid <= w_wr_valid_nx;
      r_rd_start <= w_rd_start_nx;
    end
  end

  always_comb begin
    w_state_nx    = r_state;
    w_cnt_nx      = r_bitcnt;
    w_shift_nx    = r_shift;
    w_rw_nx       = r_rw;
    w_snap_nx     = r_snap;
    w_idx_nx      = r_idx;
    w_oe_nx       = r_sda_oe;
    w_busy_nx     = r_busy;
    w_wr_data_nx  = r_wr_data;
    w_wr_valid_nx = 1'b0;
    w_rd_start_nx = 1'b0;
    if (w_stop) begin
      w_state_nx = ST_IDLE;
      w_oe_nx    = 1'b0;
      w_busy_nx  = 1'b0;
    end else if (w_start) begin
      w_state_nx = ST_ADDR;
      w_cnt_nx   = '0;
      w_oe_nx    = 1'b0;
    end else begin
      case (r_state)
        ST_ADDR: if (w_scl_rise) begin
          w_shift_nx = {r_shift[5:0], w_sda};
          w_cnt_nx   = r_bitcnt + 4'd1;
          if (r_bitcnt == 4'd7) begin
            if (r_shift == DEV_ADDR) begin
              w_state_nx = ST_ADDR_ACK;
              w_rw_nx    = w_sda;
              w_busy_nx  = 1'b1;
            end else begin
              w_state_nx = ST_IGNORE;
              w_busy_nx  = 1'b0;
            end
          end
        end
        ST_ADDR_ACK: if (w_scl_fall) begin
          if (!r_sda_oe) begin
            w_oe_nx = 1'b1;
          end else begin
            w_cnt_nx = '0;
            if (r_rw) begin
              w_state_nx    = ST_RD_BYTE;
              w_snap_nx     = io_bus.rd_image;
              w_idx_nx      = '0;
              w_rd_start_nx = 1'b1;
              w_oe_nx       = ~io_bus.rd_image[IMG_W-1];
            end else begin
              w_state_nx = ST_WR_BYTE;
              w_oe_nx    = 1'b0;
            end
          end
        end
        ST_WR_BYTE: if (w_scl_rise) begin
          w_shift_nx = {r_shift[5:0], w_sda};
          w_cnt_nx   = r_bitcnt + 4'd1;
          if (r_bitcnt == 4'd7) begin
            w_wr_data_nx  = {r_shift, w_sda};
            w_wr_valid_nx = 1'b1;
            w_state_nx    = ST_WR_ACK;
          end
        end
        ST_WR_ACK: if (w_scl_fall) begin
          if (!r_sda_oe) begin
            w_oe_nx = 1'b1;
          end else begin
            w_oe_nx    = 1'b0;
            w_cnt_nx   = '0;
            w_state_nx = ST_WR_BYTE;
          end
        end
        ST_RD_BYTE: begin
          if (w_scl_rise) begin
            w_cnt_nx = r_bitcnt + 4'd1;
          end else if (w_scl_fall) begin
            if (r_bitcnt == 4'd8) begin
              w_state_nx = ST_RD_ACK;
              w_oe_nx    = 1'b0;
            end else begin
              w_oe_nx = ~w_cur_bit;
            end
          end
        end
        ST_RD_ACK: begin
          if (w_scl_rise && w_sda) begin
            w_state_nx = ST_IGNORE;
            w_oe_nx    = 1'b0;
            w_busy_nx  = 1'b0;
          end else if (w_scl_fall) begin
            w_state_nx = ST_RD_BYTE;
            w_cnt_nx   = '0;
            w_idx_nx   = w_idx_inc;
            w_oe_nx    = ~w_nxt_msb;
          end
        end
        default: ;
      endcase
    end
  end

  assign io_bus.sda_oe   = r_sda_oe;
  assign io_bus.wr_data  = r_wr_data;
  assign io_bus.wr_valid = r_wr_valid;
  assign io_bus.rd_start = r_rd_start;
  assign io_bus.busy     = r_busy;
endmodule

// File: tb/tb_i2c_sensor_target.sv
// Directed bench for i2c_sensor_target: bit-banged I2C initiator with
// open-drain line model, table-driven write/read transactions plus corner sequences.
`timescale 1ns/1ps
module tb_i2c_sensor_target;
  localparam int unsigned Q = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        r_m_scl = 1'b1;
  logic        r_m_sda = 1'b1;
  logic [15:0] r_img = 16'hA55A;

  always #5 clk = ~clk;

  i2c_sensor_target_if #(.RD_BYTES(2)) bus_if ();

  assign bus_if.scl_in   = r_m_scl;
  assign bus_if.sda_in   = r_m_sda & ~bus_if.sda_oe;
  assign bus_if.rd_image = r_img;

  i2c_sensor_target #(.DEV_ADDR(7'h38), .RD_BYTES(2)) dut (
    .clk    (clk),
    .rst    (rst),
    .io_bus (bus_if.slave)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  logic mon_clr = 1'b0;
  int   n_wv, n_rs;
  logic oe_seen, busy_seen;

  always @(negedge clk) begin
    if (mon_clr) begin
      n_wv <= 0; n_rs <= 0; oe_seen <= 1'b0; busy_seen <= 1'b0;
    end else begin
      if (bus_if.wr_valid) n_wv <= n_wv + 1;
      if (bus_if.rd_start) n_rs <= n_rs + 1;
      if (bus_if.sda_oe)   oe_seen <= 1'b1;
      if (bus_if.busy)     busy_seen <= 1'b1;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic wq(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  task automatic mon_reset();
    @(posedge clk); mon_clr = 1'b1;
    @(posedge clk); mon_clr = 1'b0;
  endtask

  task automatic i2c_start();
    r_m_sda = 1'b1; wq(Q);
    r_m_scl = 1'b1; wq(Q);
    r_m_sda = 1'b0; wq(Q);
    r_m_scl = 1'b0; wq(Q);
  endtask

  task automatic i2c_stop();
    r_m_sda = 1'b0; wq(Q);
    r_m_scl = 1'b1; wq(Q);
    r_m_sda = 1'b1; wq(Q);
  endtask

  task automatic wr_bit(input logic b);
    r_m_sda = b; wq(Q);
    r_m_scl = 1'b1; wq(Q);
    r_m_scl = 1'b0; wq(Q);
  endtask

  task automatic rd_bit(output logic b);
    r_m_sda = 1'b1; wq(Q);
    r_m_scl = 1'b1; wq(Q/2);
    b = bus_if.sda_in; wq(Q/2);
    r_m_scl = 1'b0; wq(Q);
  endtask

  task automatic wr_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) wr_bit(d[i]);
    rd_bit(ack);
  endtask

  task automatic rd_byte(input logic ack, output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      rd_bit(b);
      d[i] = b;
    end
    wr_bit(ack);
  endtask

  typedef struct {
    logic [7:0]  addr;
    logic [7:0]  data;
    logic        exp_aack;
    logic        exp_dack;
    logic [7:0]  exp_wr;
    int unsigned exp_nwv;
    logic        exp_busy;
  } wr_vec_t;

  typedef struct {
    logic [15:0] img;
    logic [7:0]  exp_b0;
    logic [7:0]  exp_b1;
  } rd_vec_t;

  wr_vec_t wv[6];
  rd_vec_t rv[4];

  initial begin
    logic       ack;
    logic [7:0] d;
    logic       b;

    wv[0] = '{8'h70, 8'h06, 1'b0, 1'b0, 8'h06, 1, 1'b1};
    wv[1] = '{8'h70, 8'hFF, 1'b0, 1'b0, 8'hFF, 1, 1'b1};
    wv[2] = '{8'h72, 8'h55, 1'b1, 1'b1, 8'hFF, 0, 1'b0};
    wv[3] = '{8'h70, 8'h00, 1'b0, 1'b0, 8'h00, 1, 1'b1};
    wv[4] = '{8'h10, 8'h81, 1'b1, 1'b1, 8'h00, 0, 1'b0};
    wv[5] = '{8'h70, 8'h81, 1'b0, 1'b0, 8'h81, 1, 1'b1};
    rv[0] = '{16'hA55A, 8'hA5, 8'h5A};
    rv[1] = '{16'h1234, 8'h12, 8'h34};
    rv[2] = '{16'hFF00, 8'hFF, 8'h00};
    rv[3] = '{16'h0080, 8'h00, 8'h80};

    rst = 1'b1;
    wq(4);
    chk("rst_sda_oe",   32'(bus_if.sda_oe),   32'h0);
    chk("rst_wr_data",  32'(bus_if.wr_data),  32'h00);
    chk("rst_wr_valid", 32'(bus_if.wr_valid), 32'h0);
    chk("rst_rd_start", 32'(bus_if.rd_start), 32'h0);
    chk("rst_busy",     32'(bus_if.busy),     32'h0);
    rst = 1'b0;
    wq(4);

    for (int i = 0; i < 6; i++) begin
      mon_reset();
      i2c_start();
      wr_byte(wv[i].addr, ack);
      chk($sformatf("wr%0d_addr_ack", i), 32'(ack), 32'(wv[i].exp_aack));
      wr_byte(wv[i].data, ack);
      chk($sformatf("wr%0d_data_ack", i), 32'(ack), 32'(wv[i].exp_dack));
      i2c_stop();
      wq(Q);
      chk($sformatf("wr%0d_wr_data", i),   32'(bus_if.wr_data), 32'(wv[i].exp_wr));
      chk($sformatf("wr%0d_wv_count", i),  32'(n_wv),           32'(wv[i].exp_nwv));
      chk($sformatf("wr%0d_busy_seen", i), 32'(busy_seen),      32'(wv[i].exp_busy));
      chk($sformatf("wr%0d_busy_end", i),  32'(bus_if.busy),    32'h0);
    end

    for (int i = 0; i < 4; i++) begin
      r_img = rv[i].img;
      mon_reset();
      i2c_start();
      wr_byte(8'h71, ack);
      chk($sformatf("rd%0d_addr_ack", i), 32'(ack), 32'h0);
      rd_byte(1'b0, d);
      chk($sformatf("rd%0d_byte0", i), 32'(d), 32'(rv[i].exp_b0));
      rd_byte(1'b1, d);
      chk($sformatf("rd%0d_byte1", i), 32'(d), 32'(rv[i].exp_b1));
      chk($sformatf("rd%0d_oe_after_nack", i), 32'(bus_if.sda_oe), 32'h0);
      chk($sformatf("rd%0d_busy_after_nack", i), 32'(bus_if.busy), 32'h0);
      i2c_stop();
      chk($sformatf("rd%0d_rd_start_count", i), 32'(n_rs), 32'h1);
    end

    // Mismatched address followed by 8 bytes: target must stay off the bus
    mon_reset();
    i2c_start();
    wr_byte(8'h72, ack);
    for (int i = 0; i < 8; i++) wr_byte(8'(8'h11 * i), ack);
    i2c_stop();
    chk("mis_oe_seen",   32'(oe_seen),   32'h0);
    chk("mis_busy_seen", 32'(busy_seen), 32'h0);
    chk("mis_wv_count",  32'(n_wv),      32'h0);

    // Write, repeated START, 3-byte read wrapping back to byte 0
    r_img = 16'hA55A;
    mon_reset();
    i2c_start();
    wr_byte(8'h70, ack);
    chk("rs_addr_ack", 32'(ack), 32'h0);
    wr_byte(8'h01, ack);
    chk("rs_data_ack", 32'(ack), 32'h0);
    i2c_start();
    wr_byte(8'h71, ack);
    chk("rs_raddr_ack", 32'(ack), 32'h0);
    chk("rs_busy", 32'(bus_if.busy), 32'h1);
    rd_byte(1'b0, d);
    chk("rs_byte0", 32'(d), 32'hA5);
    rd_byte(1'b0, d);
    chk("rs_byte1", 32'(d), 32'h5A);
    rd_byte(1'b1, d);
    chk("rs_byte2_wrap", 32'(d), 32'hA5);
    i2c_stop();
    chk("rs_wr_data",  32'(bus_if.wr_data), 32'h01);
    chk("rs_rd_start", 32'(n_rs),           32'h1);
    chk("rs_wv_count", 32'(n_wv),           32'h1);

    // Reset during the 4th bit of a read byte (0xA5: 4th bit is 0, SDA driven low)
    r_img = 16'hA55A;
    i2c_start();
    wr_byte(8'h71, ack);
    chk("rr_addr_ack", 32'(ack), 32'h0);
    for (int i = 0; i < 3; i++) rd_bit(b);
    r_m_sda = 1'b1;
    wq(Q);
    chk("rr_oe_before_rst", 32'(bus_if.sda_oe), 32'h1);
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    chk("rr_oe_after_rst",   32'(bus_if.sda_oe), 32'h0);
    chk("rr_busy_after_rst", 32'(bus_if.busy),   32'h0);
    i2c_stop();
    mon_reset();
    i2c_start();
    wr_byte(8'h71, ack);
    chk("rr2_addr_ack", 32'(ack), 32'h0);
    rd_byte(1'b0, d);
    chk("rr2_byte0", 32'(d), 32'hA5);
    rd_byte(1'b1, d);
    chk("rr2_byte1", 32'(d), 32'h5A);
    i2c_stop();
    chk("rr2_rd_start", 32'(n_rs), 32'h1);

`ifdef I2C_TGT_GLITCH_FILTER_EN
    // One-clk SCL low glitch in the high phase of a data bit must not add a bit
    begin
      logic [7:0] gd;
      gd = 8'h5A;
      mon_reset();
      i2c_start();
      wr_byte(8'h70, ack);
      chk("gl_addr_ack", 32'(ack), 32'h0);
      for (int i = 7; i >= 0; i--) begin
        r_m_sda = gd[i]; wq(Q);
        r_m_scl = 1'b1; wq(Q/2);
        if (i == 4) begin
          r_m_scl = 1'b0; wq(1);
          r_m_scl = 1'b1;
        end
        wq(Q/2);
        r_m_scl = 1'b0; wq(Q);
      end
      rd_bit(ack);
      chk("gl_data_ack", 32'(ack), 32'h0);
      i2c_stop();
      chk("gl_wr_data",  32'(bus_if.wr_data), 32'h5A);
      chk("gl_wv_count", 32'(n_wv),           32'h1);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/i2c_sensor_target.md
I2C_SENSOR_TARGET -- requirements
Module: i2c_sensor_target

Interface
REQ-001 Parameter DEV_ADDR, default 7'h38, 7-bit target address answered on the bus.
REQ-002 Parameter RD_BYTES, default 2, number of bytes in the read image (1..4).
REQ-003 clk  input  1  system clock; all logic on posedge clk.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 scl_in  input  1  bus SCL, asynchronous to clk.
REQ-006 sda_in  input  1  bus SDA, asynchronous to clk.
REQ-007 sda_oe  output  1  1 = pull SDA low (open-drain); 0 = release.
REQ-008 rd_image  input  8*RD_BYTES  read data; byte 0 = [8*RD_BYTES-1 -: 8], sent first.
REQ-009 wr_data  output  8  last byte written by the initiator.
REQ-010 wr_valid  output  1  one-clk pulse when wr_data updates.
REQ-011 rd_start  output  1  one-clk pulse when rd_image is captured.
REQ-012 busy  output  1  high from an addressed START until STOP, NACK or mismatch.

Function
REQ-013 SCL and SDA SHALL pass through a 2-flop synchronizer before any edge or level use.
REQ-014 START = SDA falling while SCL high; STOP = SDA rising while SCL high; both are detected in any state.
REQ-015 Data SHALL be sampled on SCL rising edges, MSB first.
REQ-016 sda_oe SHALL change only on the first clk after a detected SCL falling edge.
REQ-017 States: IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, IGNORE.
REQ-018 START from any state -> ADDR, with bit counter cleared; this covers repeated START.
REQ-019 STOP from any state -> IDLE, sda_oe=0, busy=0.
REQ-020 ADDR: shift in 8 bits; if [7:1]==DEV_ADDR -> ADDR_ACK, else -> IGNORE with sda_oe held 0.
REQ-021 ADDR_ACK: drive sda_oe=1 for the 9th SCL period, busy=1; on the falling edge that ends the ACK, R/W=0 -> WR_BYTE, R/W=1 -> RD_BYTE.
REQ-022 On entry to RD_BYTE from ADDR_ACK, rd_image SHALL be snapshotted and rd_start pulsed for one clk.
REQ-023 WR_BYTE: after 8 bits, wr_data updates and wr_valid pulses within 1 clk of the 8th SCL rise; then WR_ACK drives ACK (sda_oe=1) and returns to WR_BYTE.
REQ-024 RD_BYTE: sda_oe = ~bit for 8 SCL periods; then RD_ACK releases SDA and samples the initiator's ACK.
REQ-025 RD_ACK: ACK (SDA=0) -> next byte; after byte RD_BYTES-1 the index wraps to byte 0 (same snapshot, no new rd_start); NACK -> IGNORE, sda_oe=0, busy=0.
REQ-026 IGNORE: sda_oe=0 and the bus is not touched until the next START or STOP.
REQ-027 A single-clk STOP coinciding with an SCL edge SHALL take priority over the edge.
REQ-028 Outputs SHALL be registered; there are no combinational paths from scl_in or sda_in to outputs.

Reset
REQ-029 On rst: state=IDLE, sda_oe=0, wr_data=8'h00, wr_valid=0, rd_start=0, busy=0, synchronizers=1 (idle bus).
REQ-030 rst asserted mid-transfer SHALL release SDA on the next clk; the block stays in IDLE until a fresh START.

Configuration
REQ-031 I2C_TGT_GLITCH_FILTER_EN defined: after the synchronizer, SCL and SDA each pass a 3-sample majority filter, so pulses of 1 clk or less are rejected and latency grows by 2 clk.
REQ-032 I2C_TGT_GLITCH_FILTER_EN undefined: no filter; synchronizer output is used directly.

Verification
REQ-033 Write 0x70, 0x06, STOP -> ACK on address and data; wr_data=0x06; one wr_valid pulse; busy falls at STOP.
REQ-034 Read 0x71 with rd_image=16'hA55A, ACK then NACK -> bytes 0xA5, 0x5A on SDA; one rd_start pulse; sda_oe=0 after NACK.
REQ-035 Address 0x72 (mismatch) then 8 bytes -> sda_oe never asserted; busy stays 0; no wr_valid.
REQ-036 Write 0x70, 0x01, repeated START, 0x71, read 3 bytes with ACK,ACK,NACK -> 0xA5, 0x5A, 0xA5 (wrap).
REQ-037 rst asserted during 4th bit of a read byte -> sda_oe=0 next clk; the next read starts at byte 0.
REQ-038 With I2C_TGT_GLITCH_FILTER_EN: 1-clk low glitch on SCL during a data bit -> no bit shift; data unchanged.
